phy_tx_lane_sched: RTL and testbench

Round-robin scheduler that shares the phy_tx 32-to-8 byte serializer among N_REQ word sources. It pops one 32-bit word at a time from the granted source and holds it stable on the serializer input for exactly four clk_4f cycles, one word slot. Back-to-back words keep the serializer's valid high, so its internal byte counter wraps without a gap. The block sits between the per-lane transmit FIFOs and the serializer in phy_tx.

---
 rtl/phy_tx_pkg.sv | 24 ++
 rtl/phy_tx_rr_pick.sv | 43 ++++
 rtl/phy_tx_lane_sched.sv | 116 +++++++++++
 tb/tb_phy_tx_lane_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_pkg
//  Description : Shared constants and types for the phy_tx transmit path.
//                WORD_W          - serializer input word width (fixed at 32)
//                BYTES_PER_WORD  - bytes shifted out per word slot
//                COM_WORD        - filler word sent when no lane has data
//                                  (PHY_TX_SCHED_IDLE_COM_EN builds only)
//                sched_state_t   - scheduler FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_pkg;

   localparam int          WORD_W         = 32;
   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] COM_WORD       = 32'hBCBC_BCBC;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_t;

endpackage : phy_tx_pkg
`default_nettype wire

// File: rtl/phy_tx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_rr_pick
//  Description : Combinational rotating-priority picker. Searches req starting
//                at rr_ptr+1 and wrapping modulo N_REQ; the first set bit wins.
//  Ports       : req     in  N_REQ  request vector
//                rr_ptr  in  PTR_W  index of the last winner
//                any     out 1      at least one request is set
//                winner  out PTR_W  index of the winning request (0 if none)
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_rr_pick #(
   parameter  int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic             any,
   output logic [PTR_W-1:0] winner
);

   int idx;

   // Offsets 1..N_REQ visit every lane exactly once, the last one being
   // rr_ptr itself, so the previous winner has the lowest priority.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!any && req[PTR_W'(idx)]) begin
            any    = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

endmodule : phy_tx_rr_pick
`default_nettype wire

// File: rtl/phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_lane_sched
//  Description : Round-robin scheduler feeding the phy_tx 32-to-8 serializer
//                from N_REQ word sources. Each popped word is held on
//                conv_data for one four-cycle word slot; back-to-back words
//                keep conv_valid high with no gap.
//  Ports       : clk_4f      in  1          byte-rate clock
//                reset       in  1          synchronous active-high reset
//                req_valid   in  N_REQ      source has a word available
//                req_data    in  N_REQ*32   source i word in [32*i+31:32*i]
//                req_pop     out N_REQ      one-hot pop, word consumed this cycle
//                conv_data   out 32         word on the serializer input
//                conv_valid  out 1          serializer valid
//                grant_id    out clog2(N)   source of the word on conv_data
//                slot_cnt    out 2          byte index being serialized
//  Config      : PHY_TX_SCHED_IDLE_COM_EN - when defined, an empty load point
//                in SEND loads COM_WORD instead of returning to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_lane_sched
   import phy_tx_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int WORD_W = phy_tx_pkg::WORD_W,
   localparam int PTR_W  = $clog2(N_REQ)
) (
   input  logic                    clk_4f,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*WORD_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_pop,
   output logic [WORD_W-1:0]       conv_data,
   output logic                    conv_valid,
   output logic [PTR_W-1:0]        grant_id,
   output logic [1:0]              slot_cnt
);

   localparam logic [1:0]       LAST_BYTE   = 2'(BYTES_PER_WORD - 1);
   localparam logic [PTR_W-1:0] RR_PTR_INIT = PTR_W'(N_REQ - 1);

   sched_state_t        state;
   logic [PTR_W-1:0]    rr_ptr;
   logic                any;
   logic [PTR_W-1:0]    winner;
   logic                load_pt;
   logic [WORD_W-1:0]   words [N_REQ];

   // Flat input bus viewed as one word per source.
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign words[i] = req_data[i*WORD_W +: WORD_W];
   end

   phy_tx_rr_pick #(
      .N_REQ  (N_REQ)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .any    (any),
      .winner (winner)
   );

   // A new word may be taken whenever idle, or on the last byte of a slot so
   // the next word lands exactly as the serializer counter wraps.
   assign load_pt = (state == IDLE) || (slot_cnt == LAST_BYTE);

   // Pop is suppressed during reset so a source never loses a word that the
   // reset would discard.
   always_comb begin
      req_pop = '0;
      if (!reset && load_pt && any) begin
         req_pop[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         conv_data  <= '0;
         conv_valid <= 1'b0;
         grant_id   <= '0;
         slot_cnt   <= '0;
         state      <= IDLE;
         rr_ptr     <= RR_PTR_INIT;
      end else if (load_pt) begin
         slot_cnt <= '0;
         if (any) begin
            conv_data  <= words[winner];
            conv_valid <= 1'b1;
            grant_id   <= winner;
            rr_ptr     <= winner;
            state      <= SEND;
         end else begin
`ifdef PHY_TX_SCHED_IDLE_COM_EN
            // Keep the link busy with filler once it has started; grant_id
            // and rr_ptr are left alone so fairness is unaffected.
            if (state == SEND) begin
               conv_data  <= COM_WORD;
               conv_valid <= 1'b1;
               state      <= SEND;
            end else begin
               conv_valid <= 1'b0;
               state      <= IDLE;
            end
`else
            // conv_data keeps its last word; only valid drops.
            conv_valid <= 1'b0;
            state      <= IDLE;
`endif
         end
      end else begin
         slot_cnt <= slot_cnt + 2'd1;
      end
   end

endmodule : phy_tx_lane_sched
`default_nettype wire

// File: tb/tb_phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_tx_lane_sched
//  Description : Directed self-checking bench for phy_tx_lane_sched (N_REQ=4).
//                Expectations follow the PHY_TX_SCHED_IDLE_COM_EN setting of
//                the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_tx_lane_sched;

   localparam int N = 4;

   logic           clk_4f = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*32-1:0] req_data;
   logic [N-1:0]   req_pop;
   logic [31:0]    conv_data;
   logic           conv_valid;
   logic [1:0]     grant_id;
   logic [1:0]     slot_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] wd [N];

   phy_tx_lane_sched #(
      .N_REQ      (N)
   ) dut (
      .clk_4f     (clk_4f),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_pop    (req_pop),
      .conv_data  (conv_data),
      .conv_valid (conv_valid),
      .grant_id   (grant_id),
      .slot_cnt   (slot_cnt)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic load_words();
      for (int i = 0; i < N; i++) begin
         req_data[32*i +: 32] = wd[i];
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Checks one full word slot of grant g carrying word d. mid is applied to
   // req_valid in byte 2 (the cycle before the load point); pop_exp is the
   // pop expected at the load point in byte 3.
   task automatic run_slot(input logic [1:0] g, input logic [31:0] d,
                           input logic [N-1:0] mid, input logic [N-1:0] pop_exp);
      for (int s = 0; s < 4; s++) begin
         if (s == 2) req_valid = mid;
         #1;
         check("slot_valid", {31'd0, conv_valid}, 32'd1);
         check("slot_cnt",   {30'd0, slot_cnt}, s);
         check("slot_grant", {30'd0, grant_id}, {30'd0, g});
         check("slot_data",  conv_data, d);
         check("slot_pop",   {28'd0, req_pop}, (s == 3) ? {28'd0, pop_exp} : 32'd0);
         tick();
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_data",  conv_data, 32'd0);
      check("rst_valid", {31'd0, conv_valid}, 32'd0);
      check("rst_grant", {30'd0, grant_id}, 32'd0);
      check("rst_slot",  {30'd0, slot_cnt}, 32'd0);
      req_valid = 4'b1111;
      #1;
      check("rst_nopop", {28'd0, req_pop}, 32'd0);
      req_valid = '0;
      reset     = 1'b0;

      // ---------------- single source ----------------
      wd[0] = 32'hA1B2C3D4; wd[1] = 32'h0; wd[2] = 32'h0; wd[3] = 32'h0;
      load_words();
      req_valid = 4'b0001;
      #1;
      check("single_pop", {28'd0, req_pop}, 32'h1);
      tick();
      req_valid = '0;
`ifdef PHY_TX_SCHED_IDLE_COM_EN
      run_slot(2'd0, 32'hA1B2C3D4, 4'b0000, 4'b0000);
      run_slot(2'd0, 32'hBCBC_BCBC, 4'b0000, 4'b0000);
      run_slot(2'd0, 32'hBCBC_BCBC, 4'b0000, 4'b0000);
`else
      run_slot(2'd0, 32'hA1B2C3D4, 4'b0000, 4'b0000);
      for (int c = 0; c < 2; c++) begin
         check("single_idle_valid", {31'd0, conv_valid}, 32'd0);
         check("single_idle_slot",  {30'd0, slot_cnt}, 32'd0);
         check("single_idle_data",  conv_data, 32'hA1B2C3D4);
         check("single_idle_pop",   {28'd0, req_pop}, 32'd0);
         tick();
      end
`endif

      // ---------------- all four sources streaming ----------------
      do_reset();
      wd[0] = 32'hD0D0_0000; wd[1] = 32'hD1D1_1111;
      wd[2] = 32'hD2D2_2222; wd[3] = 32'hD3D3_3333;
      load_words();
      req_valid = 4'b1111;
      #1;
      check("rr_first_pop", {28'd0, req_pop}, 32'h1);
      tick();
      for (int k = 0; k < 6; k++) begin
         run_slot(2'(k % 4), wd[k % 4], 4'b1111, 4'(4'b0001 << ((k + 1) % 4)));
      end

      // ---------------- sources 1 and 3, then 2 raised ----------------
      do_reset();
      req_valid = 4'b1010;
      #1;
      check("alt_first_pop", {28'd0, req_pop}, 32'h2);
      tick();
      run_slot(2'd1, wd[1], 4'b1010, 4'b1000);
      run_slot(2'd3, wd[3], 4'b1110, 4'b0010);
      run_slot(2'd1, wd[1], 4'b1110, 4'b0100);
      run_slot(2'd2, wd[2], 4'b1110, 4'b1000);
      run_slot(2'd3, wd[3], 4'b0000, 4'b0000);
`ifdef PHY_TX_SCHED_IDLE_COM_EN
      check("alt_end_valid", {31'd0, conv_valid}, 32'd1);
      check("alt_end_data",  conv_data, 32'hBCBC_BCBC);
      check("alt_end_grant", {30'd0, grant_id}, 32'd3);
`else
      check("alt_end_valid", {31'd0, conv_valid}, 32'd0);
      check("alt_end_data",  conv_data, wd[3]);
`endif

      // ---------------- reset mid-slot ----------------
      do_reset();
      wd[0] = 32'h11223344;
      load_words();
      req_valid = 4'b0001;
      #1;
      check("mid_pop", {28'd0, req_pop}, 32'h1);
      tick();
      tick();
      tick();
      check("mid_slot2", {30'd0, slot_cnt}, 32'd2);
      check("mid_data",  conv_data, 32'h11223344);
      reset = 1'b1;
      #1;
      check("mid_rst_nopop", {28'd0, req_pop}, 32'd0);
      tick();
      check("mid_rst_data",  conv_data, 32'd0);
      check("mid_rst_valid", {31'd0, conv_valid}, 32'd0);
      check("mid_rst_slot",  {30'd0, slot_cnt}, 32'd0);
      check("mid_rst_grant", {30'd0, grant_id}, 32'd0);
      reset     = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("mid_restart_pop", {28'd0, req_pop}, 32'h1);
      tick();
      check("mid_restart_grant", {30'd0, grant_id}, 32'd0);
      check("mid_restart_valid", {31'd0, conv_valid}, 32'd1);

      // ---------------- source drops before its load point ----------------
      do_reset();
      wd[0] = 32'hE0E0_0000; wd[1] = 32'hE1E1_1111;
      wd[2] = 32'hE2E2_2222; wd[3] = 32'hE3E3_3333;
      load_words();
      req_valid = 4'b0110;
      #1;
      check("drop_first_pop", {28'd0, req_pop}, 32'h2);
      tick();
      run_slot(2'd1, wd[1], 4'b1010, 4'b1000);
      run_slot(2'd3, wd[3], 4'b0000, 4'b0000);
`ifdef PHY_TX_SCHED_IDLE_COM_EN
      check("drop_com_valid", {31'd0, conv_valid}, 32'd1);
      check("drop_com_data",  conv_data, 32'hBCBC_BCBC);
      check("drop_com_grant", {30'd0, grant_id}, 32'd3);
      check("drop_com_pop",   {28'd0, req_pop}, 32'd0);
`else
      check("drop_idle_valid", {31'd0, conv_valid}, 32'd0);
      check("drop_idle_slot",  {30'd0, slot_cnt}, 32'd0);
      req_valid = 4'b0001;
      #1;
      check("drop_idle_pop", {28'd0, req_pop}, 32'h1);
      tick();
      check("drop_next_valid", {31'd0, conv_valid}, 32'd1);
      check("drop_next_data",  conv_data, wd[0]);
      check("drop_next_grant", {30'd0, grant_id}, 32'd0);
`endif

      req_valid = '0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_phy_tx_lane_sched
`default_nettype wire
